// File: rtl/pipelined_main_decoder.sv
// pipelined_main_decoder: D-stage main decoder for the RV32 matrix-MAC core.
// Decodes the opcode, registers the control bundle into the D/E boundary and
// sequences the multi-cycle custom MAC with a two-state FSM (IDLE, MAC_RUN).
// Optional build macro: ILLEGAL_OP_TRAP_EN enables the illegal-opcode pulse
// (illegal_e) and sticky flag (illegal_seen); without it both are tied to 0.
module pipelined_main_decoder #(
  parameter int unsigned MAC_LEN    = 4,
  parameter int unsigned CNT_W      = 2,
  parameter logic [6:0]  MAC_OPCODE = 7'b0001011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic             instr_valid,
  input  logic             stall_in,
  input  logic             flush,
  output logic             RegWrite_E,
  output logic [2:0]       ImmSrc_E,
  output logic             ALUSrc_E,
  output logic             MemWrite_E,
  output logic [1:0]       ResultSrc_E,
  output logic             Branch_E,
  output logic             Jump_E,
  output logic [1:0]       ALUOp_E,
  output logic             mac_en_e,
  output logic [CNT_W-1:0] mac_step_e,
  output logic             mac_last_e,
  output logic             busy_d,
  output logic             illegal_e,
  output logic             illegal_seen
);

  // Elaboration-time parameter sanity.
  if (MAC_LEN < 1) begin : gen_bad_mac_len
    $error("MAC_LEN must be at least 1");
  end
  if (CNT_W < 1 || (MAC_LEN > 1 && (1 << CNT_W) < MAC_LEN)) begin : gen_bad_cnt_w
    $error("CNT_W too narrow for MAC_LEN");
  end

  // RV32 opcodes handled by the fixed part of the decode table.
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpB   = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111;

  localparam logic [CNT_W-1:0] LastStep  = CNT_W'(MAC_LEN - 1);
  localparam logic             SingleMac = (MAC_LEN == 1);

  typedef enum logic [0:0] {
    StIdle,
    StMacRun
  } state_e;

  // Everything that crosses the D/E boundary, except the optional trap flags.
  typedef struct packed {
    logic             regWrite;
    logic [2:0]       immSrc;
    logic             aluSrc;
    logic             memWrite;
    logic [1:0]       resultSrc;
    logic             branch;
    logic             jump;
    logic [1:0]       aluOp;
    logic             macEn;
    logic [CNT_W-1:0] macStep;
  } ctrl_t;

  state_e stateQ, stateD;
  ctrl_t  ctrlQ, ctrlD;
  ctrl_t  decoded;
  logic   isMac;
  logic   isKnown;
  logic   macStepping;
  logic   [CNT_W-1:0] stepInc;

  // D-stage decode of the incoming opcode into a full control bundle.
  always_comb begin
    decoded = '0;
    isMac   = 1'b0;
    isKnown = 1'b1;
    if (Op == MAC_OPCODE) begin
      // The accumulator is written back only on the final step.
      isMac            = 1'b1;
      decoded.aluOp    = 2'b10;
      decoded.macEn    = 1'b1;
      decoded.macStep  = '0;
      decoded.regWrite = SingleMac;
    end else begin
      case (Op)
        OpR: begin
          decoded.regWrite = 1'b1;
          decoded.aluOp    = 2'b10;
        end
        OpI: begin
          decoded.regWrite = 1'b1;
          decoded.aluSrc   = 1'b1;
          decoded.aluOp    = 2'b10;
        end
        OpLw: begin
          decoded.regWrite  = 1'b1;
          decoded.aluSrc    = 1'b1;
          decoded.resultSrc = 2'b01;
        end
        OpSw: begin
          decoded.aluSrc   = 1'b1;
          decoded.memWrite = 1'b1;
          decoded.immSrc   = 3'b001;
        end
        OpB: begin
          decoded.branch = 1'b1;
          decoded.immSrc = 3'b010;
          decoded.aluOp  = 2'b01;
        end
        OpJal: begin
          decoded.regWrite  = 1'b1;
          decoded.jump      = 1'b1;
          decoded.immSrc    = 3'b011;
          decoded.resultSrc = 2'b10;
        end
        OpLui: begin
          decoded.regWrite = 1'b1;
          decoded.aluSrc   = 1'b1;
          decoded.immSrc   = 3'b100;
          decoded.aluOp    = 2'b11;
        end
        default: isKnown = 1'b0;
      endcase
    end
  end

  // A MAC is still stepping until its counter reaches the final step; on the
  // advance out of the final step the FSM accepts the next D instruction.
  assign macStepping = (stateQ == StMacRun) && (ctrlQ.macStep != LastStep);
  assign stepInc     = ctrlQ.macStep + CNT_W'(1);

  // Next-state and next E bundle: stall > flush > MAC stepping > accept.
  always_comb begin
    stateD = stateQ;
    ctrlD  = ctrlQ;
    if (stall_in) begin
      stateD = stateQ;
      ctrlD  = ctrlQ;
    end else if (flush) begin
      stateD = StIdle;
      ctrlD  = '0;
    end else if (macStepping) begin
      stateD           = StMacRun;
      ctrlD.macStep    = stepInc;
      ctrlD.regWrite   = (stepInc == LastStep);
    end else begin
      ctrlD  = instr_valid ? decoded : '0;
      stateD = (instr_valid && isMac && !SingleMac) ? StMacRun : StIdle;
    end
  end

  // D/E pipeline register and FSM state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      ctrlQ  <= '0;
    end else begin
      stateQ <= stateD;
      ctrlQ  <= ctrlD;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegalQ, illegalD;
  logic seenQ, seenD;

  // Trap flags follow the same stall/flush priority as the bundle; the sticky
  // flag only ever sets, so only reset clears it.
  always_comb begin
    illegalD = illegalQ;
    if (stall_in) begin
      illegalD = illegalQ;
    end else if (flush || macStepping) begin
      illegalD = 1'b0;
    end else begin
      illegalD = instr_valid && !isMac && !isKnown;
    end
    seenD = seenQ | illegalD;
  end

  // Trap flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegalQ <= 1'b0;
      seenQ    <= 1'b0;
    end else begin
      illegalQ <= illegalD;
      seenQ    <= seenD;
    end
  end

  assign illegal_e    = illegalQ;
  assign illegal_seen = seenQ;
`else
  logic unusedKnown;
  assign unusedKnown  = isKnown;
  assign illegal_e    = 1'b0;
  assign illegal_seen = 1'b0;
`endif

  assign RegWrite_E  = ctrlQ.regWrite;
  assign ImmSrc_E    = ctrlQ.immSrc;
  assign ALUSrc_E    = ctrlQ.aluSrc;
  assign MemWrite_E  = ctrlQ.memWrite;
  assign ResultSrc_E = ctrlQ.resultSrc;
  assign Branch_E    = ctrlQ.branch;
  assign Jump_E      = ctrlQ.jump;
  assign ALUOp_E     = ctrlQ.aluOp;
  assign mac_en_e    = ctrlQ.macEn;
  assign mac_step_e  = ctrlQ.macStep;
  assign mac_last_e  = ctrlQ.macEn && (ctrlQ.macStep == LastStep);
  // Decode holds only while MAC steps remain; never a function of stall_in.
  assign busy_d      = macStepping;

endmodule

// File: tb/tb_pipelined_main_decoder.sv
// Self-checking bench for pipelined_main_decoder: directed scenarios plus
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipelined_main_decoder;

  localparam int         MacLen = 4;
  localparam int         CntW   = 2;
  localparam logic [6:0] MacOp  = 7'b0001011;
  localparam logic [6:0] OpAdd  = 7'b0110011;
  localparam logic [6:0] OpLui  = 7'b0110111;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBad  = 7'b1111111;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      Op;
  logic            instr_valid, stall_in, flush;
  logic            RegWrite_E, ALUSrc_E, MemWrite_E, Branch_E, Jump_E;
  logic [2:0]      ImmSrc_E;
  logic [1:0]      ResultSrc_E, ALUOp_E;
  logic            mac_en_e, mac_last_e, busy_d, illegal_e, illegal_seen;
  logic [CntW-1:0] mac_step_e;

  pipelined_main_decoder #(
    .MAC_LEN   (MacLen),
    .CNT_W     (CntW),
    .MAC_OPCODE(MacOp)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Op          (Op),
    .instr_valid (instr_valid),
    .stall_in    (stall_in),
    .flush       (flush),
    .RegWrite_E  (RegWrite_E),
    .ImmSrc_E    (ImmSrc_E),
    .ALUSrc_E    (ALUSrc_E),
    .MemWrite_E  (MemWrite_E),
    .ResultSrc_E (ResultSrc_E),
    .Branch_E    (Branch_E),
    .Jump_E      (Jump_E),
    .ALUOp_E     (ALUOp_E),
    .mac_en_e    (mac_en_e),
    .mac_step_e  (mac_step_e),
    .mac_last_e  (mac_last_e),
    .busy_d      (busy_d),
    .illegal_e   (illegal_e),
    .illegal_seen(illegal_seen)
  );

  always #5 clk = ~clk;

  int nCompared = 0;
  int nMismatched = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Decode table: opcode and {RegWrite, ImmSrc[3], ALUSrc, MemWrite,
  // ResultSrc[2], Branch, Jump, ALUOp[2]}.
  logic [6:0]  tblOp  [7];
  logic [11:0] tblCtl [7];
  initial begin
    tblOp[0] = 7'b0110011; tblCtl[0] = 12'b1_000_0_0_00_0_0_10;
    tblOp[1] = 7'b0010011; tblCtl[1] = 12'b1_000_1_0_00_0_0_10;
    tblOp[2] = 7'b0000011; tblCtl[2] = 12'b1_000_1_0_01_0_0_00;
    tblOp[3] = 7'b0100011; tblCtl[3] = 12'b0_001_1_1_00_0_0_00;
    tblOp[4] = 7'b1100011; tblCtl[4] = 12'b0_010_0_0_00_1_0_01;
    tblOp[5] = 7'b1101111; tblCtl[5] = 12'b1_011_0_0_10_0_1_00;
    tblOp[6] = 7'b0110111; tblCtl[6] = 12'b1_100_1_0_00_0_0_11;
  end

  // Model of what E should hold: the plain control word, the MAC progress as an
  // integer step, and the trap flags.
  logic [11:0] mCtl;
  bit          mMac;
  int          mStep;
  bit          mIllegal, mSeen;

  task automatic modelReset();
    mCtl = '0; mMac = 0; mStep = 0; mIllegal = 0; mSeen = 0;
  endtask

  task automatic modelEdge(input logic [6:0] op, input bit v, input bit s, input bit f);
    bit known;
    if (s) return;
    if (f) begin
      mCtl = '0; mMac = 0; mStep = 0; mIllegal = 0;
      return;
    end
    if (mMac && mStep < MacLen - 1) begin
      mStep++;
      mCtl[11] = (mStep == MacLen - 1);
      return;
    end
    mCtl = '0; mMac = 0; mStep = 0; mIllegal = 0;
    if (v) begin
      if (op == MacOp) begin
        mMac = 1;
        mCtl[1:0] = 2'b10;
        mCtl[11] = (MacLen == 1);
      end else begin
        known = 0;
        for (int i = 0; i < 7; i++) begin
          if (tblOp[i] == op) begin
            mCtl = tblCtl[i];
            known = 1;
          end
        end
`ifdef ILLEGAL_OP_TRAP_EN
        mIllegal = !known;
`endif
      end
    end
    mSeen = mSeen | mIllegal;
  endtask

  task automatic checkAll();
    checkEq("RegWrite_E", 32'(RegWrite_E), 32'(mCtl[11]));
    checkEq("ImmSrc_E", 32'(ImmSrc_E), 32'(mCtl[10:8]));
    checkEq("ALUSrc_E", 32'(ALUSrc_E), 32'(mCtl[7]));
    checkEq("MemWrite_E", 32'(MemWrite_E), 32'(mCtl[6]));
    checkEq("ResultSrc_E", 32'(ResultSrc_E), 32'(mCtl[5:4]));
    checkEq("Branch_E", 32'(Branch_E), 32'(mCtl[3]));
    checkEq("Jump_E", 32'(Jump_E), 32'(mCtl[2]));
    checkEq("ALUOp_E", 32'(ALUOp_E), 32'(mCtl[1:0]));
    checkEq("mac_en_e", 32'(mac_en_e), 32'(mMac));
    checkEq("mac_step_e", 32'(mac_step_e), 32'(mStep));
    checkEq("mac_last_e", 32'(mac_last_e), 32'(mMac && mStep == MacLen - 1));
    checkEq("busy_d", 32'(busy_d), 32'(mMac && mStep < MacLen - 1));
    checkEq("illegal_e", 32'(illegal_e), 32'(mIllegal));
    checkEq("illegal_seen", 32'(illegal_seen), 32'(mSeen));
  endtask

  // One clock: drive at the falling edge, predict, compare at the next one.
  task automatic cycle(input logic [6:0] op, input bit v, input bit s, input bit f);
    Op = op; instr_valid = v; stall_in = s; flush = f;
    modelEdge(op, v, s, f);
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic asyncReset();
    #2 rst = 1'b0;
    #1 modelReset();
    checkAll();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; Op = '0; instr_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    checkAll();
    checkEq("reset_busy", 32'(busy_d), 32'd0);
    rst = 1'b1;

    // Decode of LUI and JAL.
    cycle(OpLui, 1, 0, 0);
    checkEq("lui_imm", 32'(ImmSrc_E), 32'b100);
    checkEq("lui_aluop", 32'(ALUOp_E), 32'b11);
    cycle(OpJal, 1, 0, 0);
    checkEq("jal_jump", 32'(Jump_E), 32'd1);
    checkEq("jal_result", 32'(ResultSrc_E), 32'b10);

    // Full MAC with an ADD waiting behind it.
    cycle(MacOp, 1, 0, 0);
    checkEq("mac_step0", 32'(mac_step_e), 32'd0);
    checkEq("mac_busy0", 32'(busy_d), 32'd1);
    cycle(OpAdd, 1, 0, 0);
    cycle(OpAdd, 1, 0, 0);
    checkEq("mac_step2_nowb", 32'(RegWrite_E), 32'd0);
    cycle(OpAdd, 1, 0, 0);
    checkEq("mac_step3", 32'(mac_step_e), 32'd3);
    checkEq("mac_last", 32'(mac_last_e), 32'd1);
    checkEq("mac_wb", 32'(RegWrite_E), 32'd1);
    checkEq("mac_busy3", 32'(busy_d), 32'd0);
    cycle(OpAdd, 1, 0, 0);
    checkEq("add_after_mac", 32'(mac_en_e), 32'd0);

    // Stall at step 1, second stall cycle also flushes: stall wins.
    cycle(MacOp, 1, 0, 0);
    cycle(OpAdd, 1, 0, 0);
    cycle(OpAdd, 1, 1, 0);
    cycle(OpAdd, 1, 1, 1);
    checkEq("stall_hold", 32'(mac_step_e), 32'd1);
    cycle(OpAdd, 1, 0, 0);
    cycle(OpAdd, 1, 0, 0);
    checkEq("stall_resume", 32'(mac_step_e), 32'd3);

    // Flush at step 2 aborts the MAC.
    cycle(MacOp, 1, 0, 0);
    cycle(OpAdd, 0, 0, 0);
    cycle(OpAdd, 0, 0, 0);
    cycle(OpAdd, 1, 0, 1);
    checkEq("flush_busy", 32'(busy_d), 32'd0);
    checkEq("flush_wb", 32'(RegWrite_E), 32'd0);

    // Unsupported opcode.
    cycle(OpBad, 1, 0, 0);
    cycle(7'd0, 0, 0, 0);

    // Reset during MAC step 2, then idle bubbles.
    cycle(MacOp, 1, 0, 0);
    cycle(OpAdd, 0, 0, 0);
    cycle(OpAdd, 0, 0, 0);
    asyncReset();
    for (int i = 0; i < 3; i++) cycle(MacOp, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7) op = tblOp[sel];
      else if (sel == 7) op = MacOp;
      else if (sel == 8) op = OpBad;
      else op = 7'($urandom);
      if ($urandom_range(0, 249) == 0) asyncReset();
      else cycle(op, $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
